// File: rtl/blockade_audio_filter.sv
// blockade_audio_filter: decimated first-order IIR low-pass, y += (x - y) * 2^-SHIFT.
// Define BLOCKADE_LPF_STAGE2_EN to cascade a second identical stage for steeper roll-off.
module blockade_audio_filter #(
  parameter int unsigned DIV   = 20,
  parameter int unsigned SHIFT = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] in,
  output logic signed [15:0] out,
  output logic               tick
);

  // Holds x * 2^SHIFT plus its fractional residue with headroom, so the update never wraps.
  localparam int unsigned ACC_W = SHIFT + 17;
  localparam logic [15:0] CNT_LAST = 16'(DIV - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-32768);

  function automatic logic signed [ACC_W-1:0] iir_step(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [15:0]      x
  );
    logic signed [ACC_W-1:0] x_ext;
    x_ext = ACC_W'(x);
    return acc + x_ext - (acc >>> SHIFT);
  endfunction

  function automatic logic signed [15:0] sat_out(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] y;
    y = acc >>> SHIFT;
    if (y > Y_MAX) begin
      return 16'sh7fff;
    end else if (y < Y_MIN) begin
      return 16'sh8000;
    end else begin
      return $signed(y[15:0]);
    end
  endfunction

  logic [15:0]             cnt_q, cnt_d;
  logic                    tick_q, tick_d;
  logic                    tick_edge_s;
  logic signed [ACC_W-1:0] acc1_q, acc1_d;
  logic signed [15:0]      y1_q, y1_d;

  // Sample-rate divider and tick pulse generation.
  always_comb begin
    cnt_d       = cnt_q;
    tick_edge_s = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d       = 16'd0;
      tick_edge_s = 1'b1;
    end else begin
      cnt_d       = cnt_q + 16'd1;
      tick_edge_s = 1'b0;
    end
    tick_d = tick_edge_s;
  end

  // Stage 1 update: state only moves on tick edges.
  always_comb begin
    acc1_d = acc1_q;
    y1_d   = y1_q;
    if (tick_edge_s) begin
      acc1_d = iir_step(acc1_q, in);
      y1_d   = sat_out(acc1_d);
    end else begin
      acc1_d = acc1_q;
      y1_d   = y1_q;
    end
  end

  // Divider, tick and stage-1 state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= 16'd0;
      tick_q <= 1'b0;
      acc1_q <= '0;
      y1_q   <= 16'sd0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      acc1_q <= acc1_d;
      y1_q   <= y1_d;
    end
  end

`ifdef BLOCKADE_LPF_STAGE2_EN
  logic signed [ACC_W-1:0] acc2_q, acc2_d;
  logic signed [15:0]      y2_q, y2_d;

  // Stage 2 consumes the stage-1 output registered before this tick edge.
  always_comb begin
    acc2_d = acc2_q;
    y2_d   = y2_q;
    if (tick_edge_s) begin
      acc2_d = iir_step(acc2_q, y1_q);
      y2_d   = sat_out(acc2_d);
    end else begin
      acc2_d = acc2_q;
      y2_d   = y2_q;
    end
  end

  // Stage-2 state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc2_q <= '0;
      y2_q   <= 16'sd0;
    end else begin
      acc2_q <= acc2_d;
      y2_q   <= y2_d;
    end
  end

  assign out = y2_q;
`else
  assign out = y1_q;
`endif

  assign tick = tick_q;

endmodule

// File: tb/tb_blockade_audio_filter.sv
// Directed bench for blockade_audio_filter: DIV=20 instance for timing/step/convergence,
// DIV=1 instance for per-clock ticks and full-scale inputs. Follows BLOCKADE_LPF_STAGE2_EN.
module tb_blockade_audio_filter;

  logic               clk = 1'b0;
  logic               rst_a, rst_b;
  logic signed [15:0] in_a, in_b;
  logic signed [15:0] out_a, out_b;
  logic               tick_a, tick_b;
  int                 n_checks = 0;
  int                 n_errors = 0;

`ifdef BLOCKADE_LPF_STAGE2_EN
  localparam logic signed [15:0] STEP1 = 16'sd0,   STEP2 = 16'sd7;
  localparam logic signed [15:0] NEG1  = 16'sd0,   NEG2  = -16'sd1;
  localparam logic signed [15:0] RST1  = 16'sd0;
  localparam logic signed [15:0] ALT0 = 16'sd0, ALT1 = 16'sd7, ALT2 = 16'sd7, ALT3 = 16'sd15;
`else
  localparam logic signed [15:0] STEP1 = 16'sd500, STEP2 = 16'sd992;
  localparam logic signed [15:0] NEG1  = -16'sd1,  NEG2  = -16'sd2;
  localparam logic signed [15:0] RST1  = 16'sd15;
  localparam logic signed [15:0] ALT0 = 16'sd511, ALT1 = -16'sd8, ALT2 = 16'sd504, ALT3 = -16'sd16;
`endif

  blockade_audio_filter #(.DIV(20), .SHIFT(6)) dut (
    .clk(clk), .reset(rst_a), .in(in_a), .out(out_a), .tick(tick_a)
  );

  blockade_audio_filter #(.DIV(1), .SHIFT(6)) dut_div1 (
    .clk(clk), .reset(rst_b), .in(in_b), .out(out_b), .tick(tick_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One 20-edge window on the DIV=20 instance: out holds prev until the 20th edge, then nxt.
  task automatic tick_window(input string tag, input logic signed [15:0] prev,
                             input logic signed [15:0] nxt);
    logic signed [31:0] e;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      e = (k == 20) ? 32'(nxt) : 32'(prev);
      check_eq({tag, "_tick"}, 32'(tick_a), (k == 20) ? 32'sd1 : 32'sd0);
      check_eq({tag, "_out"}, 32'(out_a), e);
    end
  endtask

  initial begin
    logic signed [15:0] alt_exp [4];
    alt_exp = '{ALT0, ALT1, ALT2, ALT3};
    rst_a = 1'b0;
    rst_b = 1'b0;
    in_a  = 16'sd12345;
    in_b  = 16'sd0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("rst_out", 32'(out_a), 32'sd0);
      check_eq("rst_tick", 32'(tick_a), 32'sd0);
    end

    rst_a = 1'b1;
    in_a  = 16'sd32000;
    tick_window("step1", 16'sd0, STEP1);
    tick_window("step2", STEP1, STEP2);

    rst_a = 1'b0;
    @(negedge clk);
    check_eq("rst_pulse_out", 32'(out_a), 32'sd0);
    rst_a = 1'b1;
    in_a  = -16'sd64;
    tick_window("neg1", 16'sd0, NEG1);
    tick_window("neg2", NEG1, NEG2);

    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    in_a  = 16'sd1000;
    repeat (2000 * 20) @(negedge clk);
    check_eq("conv_out", 32'(out_a), 32'sd1000);
    check_eq("conv_tick", 32'(tick_a), 32'sd1);
    rst_a = 1'b0;
    @(negedge clk);
    check_eq("midrst_out", 32'(out_a), 32'sd0);
    check_eq("midrst_tick", 32'(tick_a), 32'sd0);
    rst_a = 1'b1;
    tick_window("restart", 16'sd0, RST1);

    rst_b = 1'b1;
    in_b  = 16'sd32767;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("div1_tick", 32'(tick_b), 32'sd1);
      check_eq("alt_out", 32'(out_b), 32'(alt_exp[i]));
      in_b = (i % 2 == 0) ? -16'sd32768 : 16'sd32767;
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      check_eq("alt_tick", 32'(tick_b), 32'sd1);
      check_eq("alt_range", (out_b >= -16'sd1024 && out_b <= 16'sd1023) ? 32'sd1 : 32'sd0,
               32'sd1);
      in_b = (in_b == 16'sd32767) ? -16'sd32768 : 16'sd32767;
    end
    in_b = 16'sd32767;
    repeat (2000) @(negedge clk);
    check_eq("full_scale_out", 32'(out_b), 32'sd32767);
    check_eq("full_scale_tick", 32'(tick_b), 32'sd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
